led_matrix_scan_ctrl: RTL and testbench



---
 rtl/led_matrix_pkg.sv | 24 ++
 rtl/led_scan_timer.sv | 64 ++++++
 rtl/led_matrix_scan_ctrl.sv | 106 ++++++++++
 tb/tb_led_matrix_scan_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared constants and helpers for the LED matrix scan controller:
// default geometry, slot-length derivation and pin polarity mapping.
package led_matrix_pkg;

  localparam int DEF_ROWS         = 8;
  localparam int DEF_COLS         = 8;
  localparam int DEF_BLANK_CYCLES = 4;
  localparam int DEF_BRIGHT_W     = 4;
  localparam int DEF_STEP_CYCLES  = 15;

  // One column slot: blanking gap followed by 2**bw PWM steps.
  function automatic int slot_cycles(int blank, int step, int bw);
    return blank + step * (1 << bw);
  endfunction

  function automatic logic drive_level(logic on, logic active_low);
    return on ^ active_low;
  endfunction

  function automatic logic idle_level(int active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Slot/column timebase: slot counter, column index, PWM step index and the
// slot-start / frame-start / frame-end strobes derived from them.
module led_scan_timer
  import led_matrix_pkg::*;
#(
  parameter int COLS         = DEF_COLS,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int BRIGHT_W     = DEF_BRIGHT_W,
  parameter int STEP_CYCLES  = DEF_STEP_CYCLES,
  parameter int COL_W        = $clog2(COLS)
) (
  input  logic                aclk,
  input  logic                areset,
  output logic [COL_W-1:0]    col_idx,
  output logic [BRIGHT_W-1:0] step,
  output logic                scan,
  output logic                slot_start,
  output logic                frame_start,
  output logic                frame_end
);

  localparam int SLOT_CYCLES = slot_cycles(BLANK_CYCLES, STEP_CYCLES, BRIGHT_W);
  localparam int CNT_W       = $clog2(SLOT_CYCLES);
  localparam int SUB_W       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_N   = CNT_W'(BLANK_CYCLES);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(STEP_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);

  logic [CNT_W-1:0] slot_cnt;
  logic [SUB_W-1:0] sub_cnt;

  // step tracks (slot_cnt - BLANK_CYCLES) / STEP_CYCLES without a divider.
  always_ff @(posedge aclk) begin
    if (areset) begin
      slot_cnt <= '0;
      sub_cnt  <= '0;
      step     <= '0;
      col_idx  <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      sub_cnt  <= '0;
      step     <= '0;
      col_idx  <= (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (slot_cnt >= BLANK_N) begin
        if (sub_cnt == SUB_LAST) begin
          sub_cnt <= '0;
          step    <= step + 1'b1;
        end else begin
          sub_cnt <= sub_cnt + 1'b1;
        end
      end
    end
  end

  assign scan        = (slot_cnt >= BLANK_N);
  assign slot_start  = (slot_cnt == '0);
  assign frame_start = slot_start && (col_idx == '0);
  assign frame_end   = (slot_cnt == SLOT_LAST) && (col_idx == COL_LAST);

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// LED matrix scan controller: double-buffered frame with valid/ready load,
// global PWM brightness and registered, polarity-configurable pin drivers.
module led_matrix_scan_ctrl
  import led_matrix_pkg::*;
#(
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter int BRIGHT_W       = DEF_BRIGHT_W,
  parameter int STEP_CYCLES    = DEF_STEP_CYCLES,
  parameter int COL_ACTIVE_LOW = 1,
  parameter int ROW_ACTIVE_LOW = 0
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [ROWS*COLS-1:0] i_frame_data,
  input  logic                 i_frame_valid,
  output logic                 o_frame_ready,
  input  logic [BRIGHT_W-1:0]  i_brightness,
  output logic [COLS-1:0]      o_col,
  output logic [ROWS-1:0]      o_row,
  output logic                 o_frame_start
);

  localparam int COL_W = $clog2(COLS);
  localparam int PIX   = ROWS * COLS;

  localparam logic [COLS-1:0] COL_IDLE = {COLS{idle_level(COL_ACTIVE_LOW)}};
  localparam logic [ROWS-1:0] ROW_IDLE = {ROWS{idle_level(ROW_ACTIVE_LOW)}};

  logic [PIX-1:0]      active_q, shadow_q;
  logic                pending_q;
  logic [BRIGHT_W-1:0] bri_q;

  logic [COL_W-1:0]    col_idx;
  logic [BRIGHT_W-1:0] step;
  logic                scan, slot_start, frame_start, frame_end;
  logic                fire;
  logic [COLS-1:0]     col_on, col_drv;
  logic [ROWS-1:0]     row_on, row_drv;

  led_scan_timer #(
    .COLS         (COLS),
    .BLANK_CYCLES (BLANK_CYCLES),
    .BRIGHT_W     (BRIGHT_W),
    .STEP_CYCLES  (STEP_CYCLES),
    .COL_W        (COL_W)
  ) u_timer (
    .aclk        (aclk),
    .areset      (areset),
    .col_idx     (col_idx),
    .step        (step),
    .scan        (scan),
    .slot_start  (slot_start),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  assign o_frame_ready = !pending_q && !areset;
  assign fire          = i_frame_valid && o_frame_ready;

  // Active buffer only changes on the frame boundary, so a scan is never torn.
  always_ff @(posedge aclk) begin
    if (areset) begin
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      bri_q     <= '0;
    end else begin
      if (slot_start) bri_q <= i_brightness;
      if (frame_end && pending_q) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end else if (fire) begin
        shadow_q <= i_frame_data;
        if (frame_end) active_q  <= i_frame_data;
        else           pending_q <= 1'b1;
      end
    end
  end

  always_comb begin
    col_on = '0;
    row_on = '0;
    if (scan) col_on[col_idx] = 1'b1;
    for (int r = 0; r < ROWS; r++)
      row_on[r] = scan && active_q[r*COLS + int'(col_idx)] && (step < bri_q);
    for (int c = 0; c < COLS; c++)
      col_drv[c] = drive_level(col_on[c], idle_level(COL_ACTIVE_LOW));
    for (int r = 0; r < ROWS; r++)
      row_drv[r] = drive_level(row_on[r], idle_level(ROW_ACTIVE_LOW));
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      o_col         <= COL_IDLE;
      o_row         <= ROW_IDLE;
      o_frame_start <= 1'b0;
    end else begin
      o_col         <= col_drv;
      o_row         <= row_drv;
      o_frame_start <= frame_start;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Bench for led_matrix_scan_ctrl: cycle-by-cycle comparison against a
// frame-position reference model under directed and random stimulus.
module tb_led_matrix_scan_ctrl;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int BLANK = 4;
  localparam int BW    = 4;
  localparam int STEP  = 15;
  localparam int SLOT  = BLANK + STEP * (1 << BW);
  localparam int FRAME = COLS * SLOT;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [63:0] i_frame_data = '0;
  logic        i_frame_valid = 1'b0;
  logic [3:0]  i_brightness = '0;
  logic        o_frame_ready;
  logic [7:0]  o_col, o_row;
  logic        o_frame_start;

  always #5 aclk = ~aclk;

  led_matrix_scan_ctrl dut (
    .aclk          (aclk),
    .areset        (areset),
    .i_frame_data  (i_frame_data),
    .i_frame_valid (i_frame_valid),
    .o_frame_ready (o_frame_ready),
    .i_brightness  (i_brightness),
    .o_col         (o_col),
    .o_row         (o_row),
    .o_frame_start (o_frame_start)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: m_cyc counts cycles since reset release, position in the
  // frame is derived arithmetically from it.
  bit [63:0] m_act, m_shd;
  bit        m_pend;
  int        m_bri, m_cyc;
  bit        m_fire;
  logic [7:0] e_col, e_row;
  logic       e_fs;
  bit         have_exp = 0;

  task automatic tick();
    int pos, col, sc, step;
    logic [7:0] d_col, d_row;
    logic d_fs;
    bit rdy;
    #1;
    if (have_exp) begin
      check("col", 64'(o_col), 64'(e_col));
      check("row", 64'(o_row), 64'(e_row));
      check("frame_start", 64'(o_frame_start), 64'(e_fs));
    end
    rdy = !areset && !m_pend;
    check("ready", 64'(o_frame_ready), 64'(rdy));
    m_fire = 0;
    d_col = 8'hFF;
    d_row = 8'h00;
    d_fs  = 1'b0;
    if (areset) begin
      m_cyc = 0; m_pend = 0; m_act = '0; m_shd = '0; m_bri = 0;
    end else begin
      pos = m_cyc % FRAME;
      col = pos / SLOT;
      sc  = pos % SLOT;
      d_fs = (pos == 0);
      if (sc >= BLANK) begin
        step = (sc - BLANK) / STEP;
        d_col[col] = 1'b0;
        for (int r = 0; r < ROWS; r++)
          d_row[r] = m_act[r*COLS + col] && (step < m_bri);
      end
      if (sc == 0) m_bri = int'(i_brightness);
      m_fire = i_frame_valid && rdy;
      if (pos == FRAME-1 && m_pend) begin
        m_act = m_shd; m_pend = 0;
      end else if (m_fire) begin
        m_shd = i_frame_data;
        if (pos == FRAME-1) m_act = i_frame_data;
        else                m_pend = 1;
      end
      m_cyc++;
    end
    @(posedge aclk);
    e_col = d_col; e_row = d_row; e_fs = d_fs; have_exp = 1;
    @(negedge aclk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic offer(input logic [63:0] data, input string tag);
    int tries = 0;
    i_frame_valid = 1'b1;
    i_frame_data  = data;
    do begin
      tick();
      tries++;
    end while (!m_fire && tries < 2*FRAME + 4);
    i_frame_valid = 1'b0;
    if (!m_fire) begin
      n_chk++; n_err++;
      $display("FAIL %s: frame not accepted within %0d cycles", tag, tries);
    end
  endtask

  initial begin
    int guard;
    @(negedge aclk);
    areset = 1'b1;
    run(3);
    areset = 1'b0;

    // Single pixel at full brightness.
    i_brightness = 4'd15;
    offer(64'h0000_0000_0000_0001, "single_pixel");
    run(2*FRAME);

    // Dark brightness with every pixel set.
    i_brightness = 4'd0;
    offer({64{1'b1}}, "all_ones");
    run(2*FRAME);

    // Back-to-back frames.
    i_brightness = 4'd9;
    offer({$urandom, $urandom}, "b2b_a");
    offer({$urandom, $urandom}, "b2b_b");
    run(2*FRAME);

    // Offer placed exactly on the frame-boundary cycle with the shadow empty.
    guard = 0;
    while (!((m_cyc % FRAME) == FRAME-1 && !m_pend) && guard < 3*FRAME) begin
      tick(); guard++;
    end
    i_frame_valid = 1'b1;
    i_frame_data  = 64'hA5A5_0F0F_3C3C_FF00;
    tick();
    i_frame_valid = 1'b0;
    if (!m_fire) begin
      n_chk++; n_err++;
      $display("FAIL boundary_offer: could not align offer to boundary");
    end
    run(FRAME + 10);

    // Random producer and brightness changes.
    for (int i = 0; i < 8*FRAME; i++) begin
      if ($urandom_range(0, 299) == 0) i_brightness = 4'($urandom);
      if (!i_frame_valid && $urandom_range(0, 99) == 0) begin
        i_frame_valid = 1'b1;
        i_frame_data  = ($urandom_range(0, 3) == 0) ? 64'(1) << $urandom_range(0, 63)
                                                    : {$urandom, $urandom};
      end
      tick();
      if (m_fire) i_frame_valid = 1'b0;
    end
    i_frame_valid = 1'b0;

    // Reset pulse in the middle of column 5, then blank restart.
    i_brightness = 4'd15;
    guard = 0;
    while (!(((m_cyc % FRAME) / SLOT) == 5 && (m_cyc % SLOT) == 100) && guard < 2*FRAME) begin
      tick(); guard++;
    end
    areset = 1'b1;
    tick();
    areset = 1'b0;
    run(2*FRAME);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
